// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - drain FSM encoding and guard length shared by the TX FIFO
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        WAIT  = 2'd2
    } drain_state_t;

    localparam int GUARD_LEN = 2;
    localparam logic [1:0] GUARD_LAST = 2'(GUARD_LEN - 1);

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - host/uart_tx side signals of the TX FIFO (cts_n_i under UART_TX_FIFO_CTS_EN)
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          wr_byte_i;
    logic                wr_en_i;
    logic                flush_i;
    logic                ovf_clr_i;
    logic [7:0]          tx_byte_o;
    logic                tx_en_o;
    logic                tx_ready_i;
    logic                full_o;
    logic                empty_o;
    logic [DEPTH_LOG2:0] level_o;
    logic                ovf_o;
`ifdef UART_TX_FIFO_CTS_EN
    logic                cts_n_i;

    modport slave (
        input  wr_byte_i, wr_en_i, flush_i, ovf_clr_i, tx_ready_i, cts_n_i,
        output tx_byte_o, tx_en_o, full_o, empty_o, level_o, ovf_o
    );
    modport master (
        output wr_byte_i, wr_en_i, flush_i, ovf_clr_i, tx_ready_i, cts_n_i,
        input  tx_byte_o, tx_en_o, full_o, empty_o, level_o, ovf_o
    );
`else
    modport slave (
        input  wr_byte_i, wr_en_i, flush_i, ovf_clr_i, tx_ready_i,
        output tx_byte_o, tx_en_o, full_o, empty_o, level_o, ovf_o
    );
    modport master (
        output wr_byte_i, wr_en_i, flush_i, ovf_clr_i, tx_ready_i,
        input  tx_byte_o, tx_en_o, full_o, empty_o, level_o, ovf_o
    );
`endif
endinterface

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - 8-bit storage, one synchronous write port, asynchronous read
module fifo_mem #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);
    logic [7:0] r_mem [2**AW];

    // No reset on the array so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO draining into uart_tx; optional CTS gating with UART_TX_FIFO_CTS_EN
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic          clk,
    input  logic          resetn,
    uart_tx_fifo_if.slave bus
);
    localparam int AW = DEPTH_LOG2;

    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic [AW:0]  w_level;
    logic         w_full;
    logic         w_empty;
    logic         w_pop;
    logic         w_wr_accept;
    logic         w_ovf_set;
    logic         w_cts_ok;
    logic [7:0]   w_rd_data;
    logic [7:0]   r_tx_byte;
    logic         r_tx_en;
    logic         r_ovf;
    logic [1:0]   r_guard_cnt;
    drain_state_t r_state;
    drain_state_t w_state_nxt;

    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A pop frees a slot in the same cycle, so a write into a full FIFO is kept.
    assign w_wr_accept = bus.wr_en_i && !bus.flush_i && (!w_full || w_pop);
    assign w_ovf_set   = bus.wr_en_i && !bus.flush_i && w_full && !w_pop;

`ifdef UART_TX_FIFO_CTS_EN
    logic r_cts_meta;
    logic r_cts_sync;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cts_meta <= 1'b1;
            r_cts_sync <= 1'b1;
        end else begin
            r_cts_meta <= bus.cts_n_i;
            r_cts_sync <= r_cts_meta;
        end
    end

    assign w_cts_ok = ~r_cts_sync;
`else
    assign w_cts_ok = 1'b1;
`endif

    fifo_mem #(.AW(AW)) u_mem (
        .clk     (clk),
        .i_we    (w_wr_accept),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (bus.wr_byte_i),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (bus.flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_accept) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)       r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (bus.ovf_clr_i) begin
            r_ovf <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && bus.tx_ready_i && w_cts_ok) begin
                    w_pop       = 1'b1;
                    w_state_nxt = GUARD;
                end
            end
            // tx_ready_i is ignored here while uart_tx deasserts it.
            GUARD: begin
                if (r_guard_cnt == GUARD_LAST) w_state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.tx_ready_i) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_guard_cnt <= '0;
            r_tx_en     <= 1'b0;
            r_tx_byte   <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_guard_cnt <= (r_state == GUARD) ? r_guard_cnt + 2'd1 : 2'd0;
            r_tx_en     <= w_pop;
            if (w_pop) r_tx_byte <= w_rd_data;
        end
    end

    assign bus.tx_byte_o = r_tx_byte;
    assign bus.tx_en_o   = r_tx_en;
    assign bus.full_o    = w_full;
    assign bus.empty_o   = w_empty;
    assign bus.level_o   = w_level;
    assign bus.ovf_o     = r_ovf;

endmodule
